pc_fetch_unit: RTL

Parametrised program-counter and instruction-fetch sequencer for the rv32 core, generalising the single-cycle PC register to XLEN width, a configurable reset vector, a trap redirect and a multi-cycle instruction-memory handshake. It owns the architectural PC and issues fetch requests to instruction memory. It holds the PC while a fetch is outstanding and exposes the fetched PC to decode when an instruction is ready. It detects misaligned control-flow targets and parks until a trap redirect.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_next_calc.sv | 41 ++++
 rtl/pc_fetch_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : pc_pkg
// Purpose : Shared fetch-sequencer state type and instruction geometry.
// Rev     : 1.0
//------------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        READY = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    localparam int INST_BYTES = 4;
    localparam int ALIGN_BITS = 2;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : pc_next_calc
// Purpose : Combinational next-PC selection and redirect alignment check.
// Rev     : 1.0
//------------------------------------------------------------------------------
module pc_next_calc
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_branch,
    input  logic            i_jalr,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_reg_target,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_pc_add_4,
    output logic            o_misaligned
);

    localparam logic [XLEN-1:0] c_jalr_mask = ~XLEN'(1);

    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_rel_target;
    logic [XLEN-1:0] w_reg_target;
    logic [XLEN-1:0] w_target;

    always_comb begin
        w_seq_pc     = i_pc + XLEN'(INST_BYTES);
        w_rel_target = i_pc + i_imm;
        w_reg_target = i_reg_target & c_jalr_mask;
        w_target     = i_jalr ? w_reg_target : w_rel_target;
        o_next_pc    = i_branch ? w_target : w_seq_pc;
        o_pc_add_4   = w_seq_pc;
        // A sequential step from an aligned PC is always aligned.
        o_misaligned = i_branch && (w_target[ALIGN_BITS-1:0] != '0);
    end

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : pc_fetch_unit
// Purpose : Architectural PC register and instruction-fetch handshake sequencer.
// Rev     : 1.0
//------------------------------------------------------------------------------
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_en,
    input  logic            branch_decision,
    input  logic            pc_immediate_jump,
    input  logic [XLEN-1:0] generated_immediate,
    input  logic [XLEN-1:0] pc_write_value,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vector,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_add_4,
    output logic            pc_valid,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] c_align_mask = ~XLEN'((1 << ALIGN_BITS) - 1);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_addr;
    logic            r_misaligned;

    fetch_state_t    w_state_nx;
    logic [XLEN-1:0] w_pc_nx;
    logic [XLEN-1:0] w_fetch_addr_nx;
    logic            w_misaligned_nx;

    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pc_add_4;
    logic            w_redirect_misaligned;
    logic [XLEN-1:0] w_trap_target;

    pc_next_calc #(
        .XLEN (XLEN)
    ) u_next_calc (
        .i_pc         (r_pc),
        .i_branch     (branch_decision),
        .i_jalr       (pc_immediate_jump),
        .i_imm        (generated_immediate),
        .i_reg_target (pc_write_value),
        .o_next_pc    (w_next_pc),
        .o_pc_add_4   (w_pc_add_4),
        .o_misaligned (w_redirect_misaligned)
    );

    assign w_trap_target = trap_vector & c_align_mask;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_VECTOR;
            r_fetch_addr <= RESET_VECTOR;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_fetch_addr <= w_fetch_addr_nx;
            r_misaligned <= w_misaligned_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_fetch_addr_nx = r_fetch_addr;
        w_misaligned_nx = r_misaligned;

        if (trap_req) begin
            w_pc_nx         = w_trap_target;
            w_misaligned_nx = 1'b0;
            case (r_state)
                FETCH, DRAIN: begin
                    // An outstanding request must complete at its original
                    // address; only once acked can the trap target be fetched.
                    if (imem_ack) begin
                        w_state_nx      = FETCH;
                        w_fetch_addr_nx = w_trap_target;
                    end else begin
                        w_state_nx = DRAIN;
                    end
                end
                default: begin
                    w_state_nx      = FETCH;
                    w_fetch_addr_nx = w_trap_target;
                end
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nx      = FETCH;
                    w_fetch_addr_nx = r_pc;
                end
                FETCH: begin
                    if (imem_ack) begin
                        w_state_nx = READY;
                    end
                end
                READY: begin
                    if (in_en) begin
                        if (w_redirect_misaligned) begin
                            w_state_nx      = FAULT;
                            w_misaligned_nx = 1'b1;
                        end else begin
                            w_state_nx      = FETCH;
                            w_pc_nx         = w_next_pc;
                            w_fetch_addr_nx = w_next_pc;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        w_state_nx      = FETCH;
                        w_fetch_addr_nx = r_pc;
                    end
                end
                FAULT: begin
                    w_state_nx = FAULT;
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        imem_req   = (r_state == FETCH) || (r_state == DRAIN);
        pc_valid   = (r_state == READY);
        imem_addr  = r_fetch_addr;
        pc_out     = r_pc;
        pc_add_4   = w_pc_add_4;
        misaligned = r_misaligned;
    end

endmodule : pc_fetch_unit
`default_nettype wire
